// File: rtl/mig_write_sequencer.sv
// rtl/mig_write_sequencer.sv - two-beat MIG write burst sequencer fed from command and data FIFOs
// One command pop and two data pops per burst; MIG command and write-data channels retire independently.
module mig_write_sequencer #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 256
) (
    input  logic                clk_ram,
    input  logic                rst_n,
    input  logic                init_calib_complete,
    output logic                cmd_fifo_rd_en,
    input  logic [29:0]         cmd_fifo_rd_data,
    input  logic [8:0]          cmd_fifo_rd_size,
    output logic                data_fifo_rd_en,
    input  logic [DATA_W-1:0]   data_fifo_rd_data,
    input  logic [9:0]          data_fifo_rd_size,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    input  logic                app_wdf_rdy,
    output logic                app_ref_req,
    output logic                app_sr_req,
    output logic                app_zq_req,
    output logic                cmd_error,
    output logic [31:0]         burst_count,
    output logic [31:0]         stall_cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LOAD0 = 3'd2;
    localparam logic [2:0] S_LOAD1 = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;

    localparam int CMD_BIT = 29;

    logic [2:0]        state;
    logic              armed;
    logic              cmd_done;
    logic              data_done;
    logic [DATA_W-1:0] beat1;
    logic              cmd_ok;
    logic              data_ok;
    logic              stall_now;
    logic              can_pop;

    assign app_cmd      = 3'b000;
    assign app_wdf_mask = '0;
    assign app_ref_req  = 1'b0;
    assign app_sr_req   = 1'b0;
    assign app_zq_req   = 1'b0;

    // A channel counts as finished once it has retired or retires on this edge.
    assign cmd_ok    = cmd_done | (app_en & app_rdy);
    assign data_ok   = data_done | (app_wdf_wren & app_wdf_end & app_wdf_rdy);
    assign stall_now = (app_en & ~app_rdy) | (app_wdf_wren & ~app_wdf_rdy);
    assign can_pop   = armed && init_calib_complete &&
                       (cmd_fifo_rd_size != 9'd0) && (data_fifo_rd_size >= 10'd2);

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            armed           <= 1'b0;
            cmd_done        <= 1'b0;
            data_done       <= 1'b0;
            beat1           <= '0;
            cmd_fifo_rd_en  <= 1'b0;
            data_fifo_rd_en <= 1'b0;
            app_addr        <= '0;
            app_en          <= 1'b0;
            app_wdf_data    <= '0;
            app_wdf_wren    <= 1'b0;
            app_wdf_end     <= 1'b0;
            cmd_error       <= 1'b0;
            burst_count     <= '0;
            stall_cycles    <= '0;
        end else begin
            // Holds off the first pop by one edge after reset release.
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (can_pop) begin
                        state           <= S_POP;
                        cmd_fifo_rd_en  <= 1'b1;
                        data_fifo_rd_en <= 1'b1;
                    end
                end
                S_POP: begin
                    state           <= S_LOAD0;
                    cmd_fifo_rd_en  <= 1'b0;
                    data_fifo_rd_en <= 1'b1;
                end
                S_LOAD0: begin
                    state           <= S_LOAD1;
                    data_fifo_rd_en <= 1'b0;
                    app_addr        <= cmd_fifo_rd_data[ADDR_W-1:0];
                    app_wdf_data    <= data_fifo_rd_data;
                    if (cmd_fifo_rd_data[CMD_BIT]) begin
                        cmd_error <= 1'b1;
                    end
                end
                S_LOAD1: begin
                    state        <= S_ISSUE;
                    beat1        <= data_fifo_rd_data;
                    app_en       <= 1'b1;
                    app_wdf_wren <= 1'b1;
                    app_wdf_end  <= 1'b0;
                    cmd_done     <= 1'b0;
                    data_done    <= 1'b0;
                end
                S_ISSUE: begin
                    if (app_en && app_rdy) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        if (!app_wdf_end) begin
                            app_wdf_data <= beat1;
                            app_wdf_end  <= 1'b1;
                        end else begin
                            app_wdf_wren <= 1'b0;
                            app_wdf_end  <= 1'b0;
                            data_done    <= 1'b1;
                        end
                    end
                    if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
                        stall_cycles <= stall_cycles + 32'd1;
                    end
                    if (cmd_ok && data_ok) begin
                        state <= S_IDLE;
                        if (burst_count != 32'hFFFF_FFFF) begin
                            burst_count <= burst_count + 32'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mig_write_sequencer.md
MIG_WRITE_SEQUENCER -- requirements
Module: mig_write_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 29: MIG app_addr width.
REQ-002 SHALL have parameter DATA_W, default 256: MIG app data width.
REQ-003 SHALL use one clock and an asynchronous active-low reset. Ports: clk_ram (input, 1, sole clock) and rst_n (input, 1, async active-low reset).
REQ-004 SHALL have port init_calib_complete: input, 1, MIG calibration done.
REQ-005 SHALL have port cmd_fifo_rd_en: output, 1, pop command/address FIFO.
REQ-006 SHALL have port cmd_fifo_rd_data: input, 30, {cmd bit, addr}, valid one cycle after rd_en.
REQ-007 SHALL have port cmd_fifo_rd_size: input, 9, entries available.
REQ-008 SHALL have port data_fifo_rd_en: output, 1, pop write-data FIFO.
REQ-009 SHALL have port data_fifo_rd_data: input, DATA_W, valid one cycle after rd_en.
REQ-010 SHALL have port data_fifo_rd_size: input, 10, entries available.
REQ-011 SHALL have ports app_addr (output, ADDR_W), app_cmd (output, 3), app_en (output, 1) and app_rdy (input, 1): MIG command channel.
REQ-012 SHALL have ports app_wdf_data (output, DATA_W), app_wdf_mask (output, DATA_W/8), app_wdf_wren (output, 1), app_wdf_end (output, 1) and app_wdf_rdy (input, 1): MIG write-data channel.
REQ-013 SHALL have ports app_ref_req, app_sr_req and app_zq_req: output, 1 each, constant 0.
REQ-014 SHALL have port cmd_error: output, 1, sticky; a command with cmd bit = 1 (read) was received.
REQ-015 SHALL have port burst_count: output, 32, completed write bursts, saturating.
REQ-016 SHALL have port stall_cycles: output, 32, ISSUE-state cycles with an unaccepted handshake, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, POP, LOAD0, LOAD1, ISSUE.
REQ-018 IDLE -> POP SHALL occur when init_calib_complete=1 && cmd_fifo_rd_size>=1 && data_fifo_rd_size>=2; otherwise the FSM stays in IDLE.
REQ-019 POP SHALL assert cmd_fifo_rd_en=1 and data_fifo_rd_en=1 for exactly one cycle, then go to LOAD0.
REQ-020 LOAD0 SHALL capture cmd_fifo_rd_data and data_fifo_rd_data as beat0, assert data_fifo_rd_en=1 for one cycle, then go to LOAD1.
REQ-021 LOAD1 SHALL capture data_fifo_rd_data as beat1, then go to ISSUE.
REQ-022 Rd_en strobes SHALL be asserted only in POP/LOAD0: exactly 1 command and 2 data pops per burst.
REQ-023 ISSUE SHALL drive app_en=1, app_addr=captured address and app_cmd=3'b000 until the first cycle with app_en && app_rdy; app_en SHALL deassert the following cycle.
REQ-024 In ISSUE, app_wdf_wren SHALL be 1 with app_wdf_data=beat0 and app_wdf_end=0 until app_wdf_rdy=1; it SHALL then present beat1 with app_wdf_end=1 until app_wdf_rdy=1.
REQ-025 Command and data channels SHALL progress independently: acceptance on one SHALL NOT wait for the other, and both MAY be accepted in the same cycle.
REQ-026 app_wdf_mask SHALL be all zeros whenever app_wdf_wren=1.
REQ-027 ISSUE -> IDLE SHALL occur in the cycle after both the command and beat1 are accepted; burst_count SHALL increment by 1 in that cycle.
REQ-028 Best-case throughput: POP at cycle t, ISSUE at t+3, burst complete at t+4, next POP no earlier than t+6.
REQ-029 A captured cmd bit = 1 SHALL set cmd_error=1 permanently (until reset); the command is still issued as a write with its two data beats.
REQ-030 stall_cycles SHALL increment in each ISSUE cycle where (app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy).
REQ-031 Both counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-032 init_calib_complete falling mid-burst SHALL NOT abort the burst; it only blocks the next IDLE -> POP.
REQ-033 app_rdy or app_wdf_rdy held low indefinitely SHALL hold ISSUE and all app_* values stable, with no FIFO pops.
REQ-034 The FSM SHALL NOT pop if cmd_fifo_rd_size>=1 but data_fifo_rd_size<2; it waits in IDLE.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state=IDLE and set every output to 0: all app_*, both rd_en strobes, cmd_error, burst_count and stall_cycles.
REQ-036 Reset asserted mid-burst SHALL discard captured command/data without retry; FIFO entries already popped are lost.
REQ-037 Outputs SHALL be registered; the first POP SHALL occur no earlier than the second clk_ram edge after rst_n rises.

Verification
REQ-038 Stimulus: calib=1, one command (addr 29'h100, cmd bit 0) and data words A, B, app_rdy=app_wdf_rdy=1. Response: one app_en pulse with addr 0x100, cmd 0; wren beats A (end=0) then B (end=1); burst_count=1; stall_cycles=0.
REQ-039 Stimulus: app_rdy=0 for 5 ISSUE cycles with app_wdf_rdy=1. Response: both data beats finish, app_en held 5+1 cycles with a stable address, stall_cycles=5, single command issued.
REQ-040 Stimulus: cmd_fifo_rd_size=3, data_fifo_rd_size=1. Response: no rd_en pulses. Then data_fifo_rd_size rises to 2. Response: POP on the next cycle.
REQ-041 Stimulus: command with cmd bit 1. Response: cmd_error=1 and stays set; a write burst is still issued; burst_count increments.
REQ-042 Stimulus: rst_n pulsed low while in ISSUE with app_wdf_rdy=0. Response: all outputs 0 immediately and the FSM in IDLE; after release, the next queued burst is issued normally.
REQ-043 Stimulus: burst_count forced near saturation (0xFFFFFFFE) and 3 bursts run. Response: count ends at 0xFFFFFFFF with no wrap.
